// File: rtl/ext_world_io_bridge.sv
// Bridge between processor I/O ports and a host: change capture into an 8-deep record FIFO plus host-written input registers.
// Optional build macro EXT_IO_TIMESTAMP_EN adds an 8-bit timestamp field to every record.
module ext_world_io_bridge (
    input  logic        clk,
    input  logic        Reset,
    input  logic [7:0]  OutExtWorld1,
    input  logic [7:0]  OutExtWorld2,
    input  logic [7:0]  OutExtWorld3,
    input  logic [7:0]  OutExtWorld4,
    output logic [7:0]  InpExtWorld1,
    output logic [7:0]  InpExtWorld2,
    output logic [7:0]  InpExtWorld3,
    output logic [7:0]  InpExtWorld4,
    input  logic        HostWrEn,
    input  logic [1:0]  HostWrPort,
    input  logic [7:0]  HostWrData,
    output logic        RecValid,
    input  logic        RecReady,
`ifdef EXT_IO_TIMESTAMP_EN
    output logic [17:0] RecData,
`else
    output logic [9:0]  RecData,
`endif
    output logic [3:0]  Level,
    output logic        Overflow,
    input  logic        OvfClr
);

`ifdef EXT_IO_TIMESTAMP_EN
    localparam int REC_W = 18;
`else
    localparam int REC_W = 10;
`endif

    logic [7:0]       out_s      [4];
    logic [7:0]       prev_q     [4];
    logic [7:0]       prev_d     [4];
    logic [7:0]       cap_q      [4];
    logic [7:0]       cap_d      [4];
    logic [7:0]       inp_q      [4];
    logic [7:0]       inp_d      [4];
    logic [3:0]       pending_q;
    logic [3:0]       pending_d;
    logic [REC_W-1:0] mem_q      [8];
    logic [REC_W-1:0] mem_d      [8];
    logic [2:0]       wr_ptr_q;
    logic [2:0]       wr_ptr_d;
    logic [2:0]       rd_ptr_q;
    logic [2:0]       rd_ptr_d;
    logic [3:0]       level_q;
    logic [3:0]       level_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [3:0]       detect_s;
    logic [3:0]       drain_s;
    logic [1:0]       drain_idx_s;
    logic             pop_s;
    logic             push_s;
    logic             can_push_s;
    logic             ovf_set_s;
    logic [REC_W-1:0] rec_s;
`ifdef EXT_IO_TIMESTAMP_EN
    logic [7:0]       ts_q;
    logic [7:0]       ts_d;
    logic [7:0]       ts_cap_q   [4];
    logic [7:0]       ts_cap_d   [4];
`endif

    // Gather the processor output ports into an indexable array.
    always_comb begin
        out_s[0] = OutExtWorld1;
        out_s[1] = OutExtWorld2;
        out_s[2] = OutExtWorld3;
        out_s[3] = OutExtWorld4;
    end

    // Change detection and lowest-index-first drain arbitration.
    always_comb begin
        pop_s      = (level_q != 4'd0) && RecReady;
        // A full FIFO still accepts a record when the head leaves at the same edge.
        can_push_s = (level_q != 4'd8) || pop_s;
        for (int i = 0; i < 4; i++) begin
            detect_s[i] = (out_s[i] != prev_q[i]);
        end
        drain_s = 4'b0000;
        if (can_push_s) begin
            if (pending_q[0]) begin
                drain_s = 4'b0001;
            end else if (pending_q[1]) begin
                drain_s = 4'b0010;
            end else if (pending_q[2]) begin
                drain_s = 4'b0100;
            end else if (pending_q[3]) begin
                drain_s = 4'b1000;
            end else begin
                drain_s = 4'b0000;
            end
        end else begin
            drain_s = 4'b0000;
        end
        push_s = |drain_s;
        case (drain_s)
            4'b0001: drain_idx_s = 2'd0;
            4'b0010: drain_idx_s = 2'd1;
            4'b0100: drain_idx_s = 2'd2;
            4'b1000: drain_idx_s = 2'd3;
            default: drain_idx_s = 2'd0;
        endcase
`ifdef EXT_IO_TIMESTAMP_EN
        rec_s = {ts_cap_q[drain_idx_s], drain_idx_s, cap_q[drain_idx_s]};
`else
        rec_s = {drain_idx_s, cap_q[drain_idx_s]};
`endif
    end

    // Next state for per-port capture, pending bits and the overflow flag.
    always_comb begin
        ovf_set_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            prev_d[i]    = out_s[i];
            cap_d[i]     = cap_q[i];
            pending_d[i] = pending_q[i] & ~drain_s[i];
`ifdef EXT_IO_TIMESTAMP_EN
            ts_cap_d[i]  = ts_cap_q[i];
`endif
            if (detect_s[i]) begin
                // Newest value wins; the loss only counts if the old one is not leaving now.
                cap_d[i]     = out_s[i];
                pending_d[i] = 1'b1;
`ifdef EXT_IO_TIMESTAMP_EN
                ts_cap_d[i]  = ts_q;
`endif
                if (pending_q[i] && !drain_s[i]) begin
                    ovf_set_s = 1'b1;
                end else begin
                    ovf_set_s = ovf_set_s;
                end
            end else begin
                cap_d[i] = cap_q[i];
            end
        end
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (OvfClr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
`ifdef EXT_IO_TIMESTAMP_EN
        ts_d = ts_q + 8'd1;
`endif
    end

    // Next state for the record FIFO storage, pointers and occupancy.
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            mem_d[j] = mem_q[j];
        end
        if (push_s) begin
            mem_d[wr_ptr_q] = rec_s;
            wr_ptr_d        = wr_ptr_q + 3'd1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 3'd1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        level_d = level_q + {3'b000, push_s} - {3'b000, pop_s};
    end

    // Next state for the host-written processor input registers.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            inp_d[i] = inp_q[i];
        end
        if (HostWrEn) begin
            case (HostWrPort)
                2'd0:    inp_d[0] = HostWrData;
                2'd1:    inp_d[1] = HostWrData;
                2'd2:    inp_d[2] = HostWrData;
                2'd3:    inp_d[3] = HostWrData;
                default: inp_d[0] = inp_q[0];
            endcase
        end else begin
            inp_d[0] = inp_q[0];
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                prev_q[i]   <= 8'h00;
                cap_q[i]    <= 8'h00;
                inp_q[i]    <= 8'h00;
`ifdef EXT_IO_TIMESTAMP_EN
                ts_cap_q[i] <= 8'h00;
`endif
            end
            for (int j = 0; j < 8; j++) begin
                mem_q[j] <= '0;
            end
            pending_q <= 4'b0000;
            wr_ptr_q  <= 3'd0;
            rd_ptr_q  <= 3'd0;
            level_q   <= 4'd0;
            ovf_q     <= 1'b0;
`ifdef EXT_IO_TIMESTAMP_EN
            ts_q      <= 8'h00;
`endif
        end else begin
            for (int i = 0; i < 4; i++) begin
                prev_q[i]   <= prev_d[i];
                cap_q[i]    <= cap_d[i];
                inp_q[i]    <= inp_d[i];
`ifdef EXT_IO_TIMESTAMP_EN
                ts_cap_q[i] <= ts_cap_d[i];
`endif
            end
            for (int j = 0; j < 8; j++) begin
                mem_q[j] <= mem_d[j];
            end
            pending_q <= pending_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
`ifdef EXT_IO_TIMESTAMP_EN
            ts_q      <= ts_d;
`endif
        end
    end

    assign RecValid     = (level_q != 4'd0);
    assign RecData      = mem_q[rd_ptr_q];
    assign Level        = level_q;
    assign Overflow     = ovf_q;
    assign InpExtWorld1 = inp_q[0];
    assign InpExtWorld2 = inp_q[1];
    assign InpExtWorld3 = inp_q[2];
    assign InpExtWorld4 = inp_q[3];

endmodule

// File: tb/tb_ext_world_io_bridge.sv
// Randomized bench for ext_world_io_bridge against a queue-based reference model, plus directed scenarios.
module tb_ext_world_io_bridge;

`ifdef EXT_IO_TIMESTAMP_EN
    localparam int RW = 18;
`else
    localparam int RW = 10;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    out_v [4];
    logic [7:0]    inp1, inp2, inp3, inp4;
    logic          hwen;
    logic [1:0]    hwport;
    logic [7:0]    hwdata;
    logic          rec_valid;
    logic          rdy;
    logic [RW-1:0] rec_data;
    logic [3:0]    level;
    logic          ovf;
    logic          ovfclr;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]    m_prev   [4];
    logic [7:0]    m_cap    [4];
    logic [7:0]    m_ts_cap [4];
    bit            m_pend   [4];
    logic [7:0]    m_inp    [4];
    logic [RW-1:0] m_fifo   [$];
    bit            m_ovf;
    logic [7:0]    m_ts;

    always #5 clk = ~clk;

    ext_world_io_bridge dut (
        .clk          (clk),
        .Reset        (rst),
        .OutExtWorld1 (out_v[0]),
        .OutExtWorld2 (out_v[1]),
        .OutExtWorld3 (out_v[2]),
        .OutExtWorld4 (out_v[3]),
        .InpExtWorld1 (inp1),
        .InpExtWorld2 (inp2),
        .InpExtWorld3 (inp3),
        .InpExtWorld4 (inp4),
        .HostWrEn     (hwen),
        .HostWrPort   (hwport),
        .HostWrData   (hwdata),
        .RecValid     (rec_valid),
        .RecReady     (rdy),
        .RecData      (rec_data),
        .Level        (level),
        .Overflow     (ovf),
        .OvfClr       (ovfclr)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] make_rec(input int i);
        logic [1:0] p;
        p = i[1:0];
`ifdef EXT_IO_TIMESTAMP_EN
        return {m_ts_cap[i], p, m_cap[i]};
`else
        return {p, m_cap[i]};
`endif
    endfunction

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit pop_b;
        bit ovfset;
        int drained;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_prev[i] = 8'h00; m_cap[i] = 8'h00; m_ts_cap[i] = 8'h00;
                m_pend[i] = 1'b0;  m_inp[i] = 8'h00;
            end
            m_fifo.delete();
            m_ovf = 1'b0;
            m_ts  = 8'h00;
        end else begin
            pop_b   = (m_fifo.size() != 0) && rdy;
            ovfset  = 1'b0;
            drained = -1;
            if (m_fifo.size() < 8 || pop_b) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_pend[i] && drained < 0) drained = i;
                end
            end
            if (pop_b) void'(m_fifo.pop_front());
            if (drained >= 0) m_fifo.push_back(make_rec(drained));
            for (int i = 0; i < 4; i++) begin
                if (out_v[i] != m_prev[i]) begin
                    if (m_pend[i] && i != drained) ovfset = 1'b1;
                    m_pend[i]   = 1'b1;
                    m_cap[i]    = out_v[i];
                    m_ts_cap[i] = m_ts;
                end else if (i == drained) begin
                    m_pend[i] = 1'b0;
                end
                m_prev[i] = out_v[i];
            end
            if (ovfset)      m_ovf = 1'b1;
            else if (ovfclr) m_ovf = 1'b0;
            if (hwen) m_inp[hwport] = hwdata;
            m_ts = m_ts + 8'd1;
        end
    endtask

    task automatic compare_all();
        check_val("rec_valid", rec_valid, (m_fifo.size() != 0));
        if (m_fifo.size() != 0) check_val("rec_data", rec_data, m_fifo[0]);
        check_val("level", level, m_fifo.size());
        check_val("overflow", ovf, m_ovf);
        check_val("inp1", inp1, m_inp[0]);
        check_val("inp2", inp2, m_inp[1]);
        check_val("inp3", inp3, m_inp[2]);
        check_val("inp4", inp4, m_inp[3]);
    endtask

    // One clock: inputs already driven, model follows the edge, outputs compared at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst = 1'b1; hwen = 1'b0; hwport = 2'd0; hwdata = 8'h00; rdy = 1'b0; ovfclr = 1'b0;
        for (int i = 0; i < 4; i++) out_v[i] = 8'h00;
        @(negedge clk);
        step();
        check_val("reset_valid", rec_valid, 1'b0);
        check_val("reset_level", level, 4'd0);
        rst = 1'b0;
        step();

        // Single change on port index 2
        rdy = 1'b1;
        out_v[2] = 8'h5A;
        step();
        check_val("single_not_yet", rec_valid, 1'b0);
        step();
        check_val("single_valid", rec_valid, 1'b1);
        check_val("single_data", rec_data[9:0], 10'h25A);
        step();
        check_val("single_level0", level, 4'd0);

        // All four ports change together
        out_v[0] = 8'h11; out_v[1] = 8'h22; out_v[2] = 8'h33; out_v[3] = 8'h44;
        step();
        step();
        check_val("burst_p0", rec_data[9:0], 10'h011);
        step();
        check_val("burst_p1", rec_data[9:0], 10'h122);
        step();
        check_val("burst_p2", rec_data[9:0], 10'h233);
        step();
        check_val("burst_p3", rec_data[9:0], 10'h344);
        check_val("burst_ovf", ovf, 1'b0);
        step();

        // Saturation with the host stalled
        rdy = 1'b0;
        for (int k = 0; k < 9; k++) begin
            out_v[0] = 8'hA0 + 8'(k);
            step();
            step();
        end
        check_val("sat_level8", level, 4'd8);
        check_val("sat_no_ovf", ovf, 1'b0);
        out_v[0] = 8'hB0;
        step();
        check_val("sat_ovf_set", ovf, 1'b1);
        ovfclr = 1'b1;
        step();
        ovfclr = 1'b0;
        check_val("sat_ovf_clr", ovf, 1'b0);
        rdy = 1'b1;
        for (int k = 0; k < 12; k++) step();
        check_val("sat_drained", level, 4'd0);

        // Host write and reset of the input registers
        hwen = 1'b1; hwport = 2'd1; hwdata = 8'hC3;
        step();
        hwen = 1'b0;
        check_val("host_inp2", inp2, 8'hC3);
        check_val("host_inp1", inp1, 8'h00);
        check_val("host_inp3", inp3, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("host_rst_inp2", inp2, 8'h00);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) out_v[i] = 8'($urandom);
            end
            rdy    = ($urandom_range(0, 3) != 0);
            hwen   = ($urandom_range(0, 3) == 0);
            hwport = 2'($urandom);
            hwdata = 8'($urandom);
            ovfclr = ($urandom_range(0, 15) == 0);
            rst    = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ext_world_io_bridge.md
EXT_WORLD_IO_BRIDGE -- requirements
Module: ext_world_io_bridge

Interface
REQ-001 The block SHALL have one clock, clk (input, 1), rising-edge; all state SHALL be updated on the rising edge of clk.
REQ-002 Reset (input, 1) SHALL be synchronous and active-high.
REQ-003 OutExtWorld1..OutExtWorld4 (input, 8 each): processor output ports, observed by the bridge.
REQ-004 InpExtWorld1..InpExtWorld4 (output, 8 each): registered values driven into the processor input ports.
REQ-005 HostWrEn (input, 1), HostWrPort (input, 2), HostWrData (input, 8): host write into one InpExtWorld register.
REQ-006 RecValid (output, 1), RecReady (input, 1), RecData (output, 10, or 18 with the macro in REQ-021): record stream to the host.
REQ-007 Level (output, 4): FIFO occupancy, 0..8.
REQ-008 Overflow (output, 1): sticky lost-value flag; OvfClr (input, 1) clears it.

Function
REQ-009 Port index p SHALL be 0..3 for OutExtWorld1..4; record format SHALL be RecData = {p[1:0], value[7:0]}.
REQ-010 Each port SHALL have a prev register; a change SHALL be detected at edge E when OutExtWorldN != prevN, and prevN SHALL load OutExtWorldN at every edge.
REQ-011 At detection, pendingN SHALL be set and capN SHALL load the new value; a later change before drain overwrites capN (newest wins).
REQ-012 A change on a port whose pending bit is already set and not being drained at the same edge SHALL set Overflow.
REQ-013 Drain arbiter: at each edge with Level<8, or with Level=8 and a pop at that edge, the lowest-index pending port SHALL be written to the FIFO and its pending bit cleared.
REQ-014 When a port is drained at the same edge that it detects a new change, pending SHALL remain set with the new value, and Overflow SHALL NOT be set.
REQ-015 Latency: a change detected at edge E with no contention SHALL be in the FIFO after E+1, with RecValid high during the cycle following E+1.
REQ-016 FIFO: 8 entries, in-order; RecData SHALL present the oldest entry whenever RecValid=1; RecValid = (Level!=0).
REQ-017 Pop SHALL occur at an edge where RecValid and RecReady are both 1; push and pop at the same edge SHALL leave Level unchanged; pointers SHALL wrap 7->0.
REQ-018 Host write: when HostWrEn=1, InpExtWorld[HostWrPort+1] SHALL take HostWrData at the edge and become visible the following cycle; the other ports SHALL hold.
REQ-019 OvfClr=1 SHALL clear Overflow at the edge; a simultaneous set event SHALL win, leaving Overflow=1.

Reset
REQ-020 While Reset=1 at an edge, the following SHALL clear: prev, cap, pending, FIFO pointers, Level, Overflow, all InpExtWorld outputs (0x00), and the timestamp counter. RecValid SHALL be 0 the following cycle; host writes and changes in that cycle SHALL be discarded.

Configuration
REQ-021 With EXT_IO_TIMESTAMP_EN defined, an 8-bit free-running counter (0 at reset, wraps 255->0) SHALL be captured per port at detection, and RecData SHALL be 18 bits = {ts[7:0], p[1:0], value[7:0]}.
REQ-022 Without EXT_IO_TIMESTAMP_EN, there SHALL be no counter, and RecData SHALL be 10 bits.

Verification
REQ-023 Reset, then OutExtWorld3 0x00->0x5A at edge E, RecReady=1 -> RecValid high in the cycle after E+1 with RecData=0x25A (p=2), then Level=0.
REQ-024 All four ports change to 0x11,0x22,0x33,0x44 at the same edge -> records come out in order p0,p1,p2,p3 on consecutive cycles, and Overflow=0.
REQ-025 RecReady=0 and 9 distinct changes on port 0 spaced 2 cycles apart -> Level saturates at 8, the 9th value stays pending, and a 10th change sets Overflow; OvfClr clears it.
REQ-026 HostWrEn=1, HostWrPort=1, HostWrData=0xC3 -> InpExtWorld2=0xC3 next cycle, with the other ports unchanged; then Reset -> all are 0x00.
REQ-027 With EXT_IO_TIMESTAMP_EN defined, a change 300 cycles after reset -> ts field = 300 mod 256 = 44 (0x2C).
